// File: rtl/pipe_collision_scorer.sv
// Game referee: bird/pipe/bound collision detection, BCD pass score and the
// IDLE/PLAY/HIT/OVER state machine that freezes and restarts the pipe controllers.
module pipe_collision_scorer #(
  parameter int unsigned BIRD_X     = 300,
  parameter int unsigned BIRD_R     = 10,
  parameter int unsigned PIPE_HW    = 50,
  parameter int unsigned GAP_H      = 50,
  parameter int unsigned CEIL_Y     = 35,
  parameter int unsigned FLOOR_Y    = 515,
  parameter int unsigned VIS_MIN    = 94,
  parameter int unsigned VIS_MAX    = 850,
  parameter int unsigned HIT_CYCLES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up,
  input  logic [9:0]  bird_y,
  input  logic [11:0] pipe0_x,
  input  logic [10:0] pipe0_y,
  input  logic [11:0] pipe1_x,
  input  logic [10:0] pipe1_y,
  output logic        freeze,
  output logic        pipe_rst,
  output logic        game_over,
  output logic        hit_flash,
  output logic [15:0] score,
  output logic [1:0]  state
);

  localparam logic [12:0] BX  = 13'(BIRD_X);
  localparam logic [12:0] BR  = 13'(BIRD_R);
  localparam logic [12:0] HW  = 13'(PIPE_HW);
  localparam logic [12:0] GH  = 13'(GAP_H);
  localparam logic [12:0] CY  = 13'(CEIL_Y);
  localparam logic [12:0] FY  = 13'(FLOOR_Y);
  localparam logic [12:0] VMN = 13'(VIS_MIN);
  localparam logic [12:0] VMX = 13'(VIS_MAX);
  localparam logic [11:0] PASS_X = 12'(BIRD_X - PIPE_HW - BIRD_R);
  localparam int unsigned CW = $clog2(HIT_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } state_t;

  state_t        cur_state, nxt_state;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   score_q, score_d, score_inc;
  logic          pipe_rst_q, pipe_rst_d;
  logic          up_q, up_rise;
  logic [11:0]   prev_x0, prev_x1;
  logic          bounds, coll0, coll1, hit;
  logic          pass0, pass1;
  logic [1:0]    pass_cnt;
  logic [4:0]    dsum;
  logic [1:0]    carry;
  logic          unused_y;

  // All terms are sums compared against sums, so nothing can underflow.
  function automatic logic pipe_collides(input logic [11:0] x, input logic [9:0] y,
                                         input logic [9:0] by);
    logic [12:0] xe, ye, be;
    xe = {1'b0, x};
    ye = {3'b0, y};
    be = {3'b0, by};
    return (xe >= VMN) && (xe <= VMX)
        && (xe + HW + BR >= BX) && (xe <= BX + HW + BR)
        && ((be + GH <= ye + BR) || (be + BR >= ye + GH));
  endfunction

  assign unused_y = pipe0_y[10] ^ pipe1_y[10];

  assign up_rise  = up & ~up_q;
  assign coll0    = pipe_collides(pipe0_x, pipe0_y[9:0], bird_y);
  assign coll1    = pipe_collides(pipe1_x, pipe1_y[9:0], bird_y);
  assign bounds   = ({3'b0, bird_y} <= CY + BR) || ({3'b0, bird_y} + BR >= FY);
  assign hit      = bounds | coll0 | coll1;
  assign pass0    = (prev_x0 >= PASS_X) && (pipe0_x < PASS_X);
  assign pass1    = (prev_x1 >= PASS_X) && (pipe1_x < PASS_X);
  assign pass_cnt = {1'b0, pass0} + {1'b0, pass1};

  // Ripple the 0..2 increment through the digits; a carry out of the
  // thousands digit means the result would exceed 9999.
  always_comb begin
    score_inc = score_q;
    carry     = pass_cnt;
    dsum      = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      dsum = {1'b0, score_q[i*4 +: 4]} + {3'b0, carry};
      if (dsum >= 5'd10) begin
        score_inc[i*4 +: 4] = 4'(dsum - 5'd10);
        carry               = 2'd1;
      end else begin
        score_inc[i*4 +: 4] = dsum[3:0];
        carry               = 2'd0;
      end
    end
    if (carry != 2'd0) score_inc = 16'h9999;
  end

  always_comb begin
    nxt_state  = cur_state;
    count_d    = count_q;
    score_d    = score_q;
    pipe_rst_d = 1'b0;
    case (cur_state)
      IDLE: if (up_rise) begin
        nxt_state  = PLAY;
        pipe_rst_d = 1'b1;
        score_d    = '0;
      end
      PLAY: if (hit) begin
        nxt_state = HIT;
        count_d   = CNT_LOAD;
      end else begin
        score_d = score_inc;
      end
      HIT: if (count_q == '0) nxt_state = OVER;
           else count_d = count_q - 1'b1;
      OVER: if (up_rise) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state  <= IDLE;
      count_q    <= '0;
      score_q    <= '0;
      pipe_rst_q <= 1'b0;
      up_q       <= 1'b0;
      prev_x0    <= '0;
      prev_x1    <= '0;
    end else begin
      cur_state  <= nxt_state;
      count_q    <= count_d;
      score_q    <= score_d;
      pipe_rst_q <= pipe_rst_d;
      up_q       <= up;
      prev_x0    <= pipe0_x;
      prev_x1    <= pipe1_x;
    end
  end

  assign freeze    = (cur_state != PLAY);
  assign game_over = (cur_state == OVER);
  assign hit_flash = (cur_state == HIT) & count_q[3];
  assign pipe_rst  = pipe_rst_q;
  assign score     = score_q;
  assign state     = cur_state;

endmodule

// File: tb/tb_pipe_collision_scorer.sv
// Directed bench for pipe_collision_scorer: a decimal-score game model checked
// every cycle, plus literal spot checks at the interesting points.
module tb_pipe_collision_scorer;

  localparam int BIRD_X = 300, BIRD_R = 10, PIPE_HW = 50, GAP_H = 50;
  localparam int CEIL_Y = 35, FLOOR_Y = 515, VIS_MIN = 94, VIS_MAX = 850;
  localparam int HIT_CYCLES = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        up = 1'b0;
  logic [9:0]  bird_y = 10'd250;
  logic [11:0] p0x = 12'd1000, p1x = 12'd1000;
  logic [10:0] p0y = 11'd250, p1y = 11'd250;
  logic        freeze, pipe_rst, game_over, hit_flash;
  logic [15:0] score;
  logic [1:0]  state;

  int vectors = 0;
  int miscompares = 0;

  pipe_collision_scorer #(
    .BIRD_X(BIRD_X), .BIRD_R(BIRD_R), .PIPE_HW(PIPE_HW), .GAP_H(GAP_H),
    .CEIL_Y(CEIL_Y), .FLOOR_Y(FLOOR_Y), .VIS_MIN(VIS_MIN), .VIS_MAX(VIS_MAX),
    .HIT_CYCLES(HIT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .up(up), .bird_y(bird_y),
    .pipe0_x(p0x), .pipe0_y(p0y), .pipe1_x(p1x), .pipe1_y(p1y),
    .freeze(freeze), .pipe_rst(pipe_rst), .game_over(game_over),
    .hit_flash(hit_flash), .score(score), .state(state)
  );

  always #5 clk = ~clk;

  function automatic bit pipe_collides(int x, int y, int by);
    int yy;
    yy = y % 1024;
    if (x < VIS_MIN || x > VIS_MAX) return 1'b0;
    if (x + PIPE_HW + BIRD_R < BIRD_X || x > BIRD_X + PIPE_HW + BIRD_R) return 1'b0;
    return (by + GAP_H <= yy + BIRD_R) || (by + BIRD_R >= yy + GAP_H);
  endfunction

  function automatic int passed(int prev, int x);
    int px;
    px = BIRD_X - PIPE_HW - BIRD_R;
    return (prev >= px && x < px) ? 1 : 0;
  endfunction

  function automatic logic [15:0] to_bcd(int s);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  // Game model: state 0..3, decimal score, cycles elapsed inside HIT.
  int m_state = 0, m_score = 0, m_k = 0, m_px0 = 0, m_px1 = 0;
  bit m_pipe_rst = 1'b0, m_up_prev = 1'b0;
  bit m_rise, m_hit;
  int m_n;

  assign m_rise = up && !m_up_prev;
  assign m_hit  = (int'(bird_y) <= CEIL_Y + BIRD_R) || (int'(bird_y) + BIRD_R >= FLOOR_Y)
               || pipe_collides(int'(p0x), int'(p0y), int'(bird_y))
               || pipe_collides(int'(p1x), int'(p1y), int'(bird_y));
  assign m_n    = passed(m_px0, int'(p0x)) + passed(m_px1, int'(p1x));

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state <= 0; m_score <= 0; m_k <= 0; m_px0 <= 0; m_px1 <= 0;
      m_pipe_rst <= 1'b0; m_up_prev <= 1'b0;
    end else begin
      m_pipe_rst <= 1'b0;
      case (m_state)
        0: if (m_rise) begin m_state <= 1; m_pipe_rst <= 1'b1; m_score <= 0; end
        1: if (m_hit) begin m_state <= 2; m_k <= 0; end
           else m_score <= (m_score + m_n > 9999) ? 9999 : m_score + m_n;
        2: if (m_k == HIT_CYCLES - 1) m_state <= 3; else m_k <= m_k + 1;
        default: if (m_rise) m_state <= 0;
      endcase
      m_up_prev <= up;
      m_px0 <= int'(p0x);
      m_px1 <= int'(p1x);
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic go_play();
    up = 1'b1; tick(1);
    up = 1'b0; tick(1);
    up = 1'b1; tick(1);
    up = 1'b0; tick(1);
  endtask

  initial begin
    #1 rst = 1'b0;

    fork
      forever begin
        logic [1:0]  e_state;
        logic        e_flash;
        logic [15:0] e_score;
        @(negedge clk);
        e_state = 2'(m_state);
        e_score = to_bcd(m_score);
        e_flash = (m_state == 2) ? 1'((((HIT_CYCLES - 1) - m_k) >> 3) & 1) : 1'b0;
        vectors++;
        if (state !== e_state || freeze !== (m_state != 1) || pipe_rst !== m_pipe_rst ||
            game_over !== (m_state == 3) || hit_flash !== e_flash || score !== e_score) begin
          miscompares++;
          $display("FAIL cycle t=%0t got/want: state %0d/%0d freeze %b/%b pipe_rst %b/%b over %b/%b flash %b/%b score %h/%h",
                   $time, state, e_state, freeze, (m_state != 1), pipe_rst, m_pipe_rst,
                   game_over, (m_state == 3), hit_flash, e_flash, score, e_score);
        end
      end
    join_none

    tick(2);
    check("reset_state", 16'(state), 16'd0);
    check("reset_freeze", 16'(freeze), 16'd1);
    check("reset_score", score, 16'h0000);
    rst = 1'b1;
    tick(2);

    // start
    up = 1'b1; tick(1);
    check("start_state", 16'(state), 16'd1);
    check("start_pipe_rst", 16'(pipe_rst), 16'd1);
    check("start_score", score, 16'h0000);
    tick(1);
    check("start_pipe_rst_drop", 16'(pipe_rst), 16'd0);
    check("start_freeze", 16'(freeze), 16'd0);
    tick(1);
    up = 1'b0; tick(1);

    // clean pass of pipe0 through the gap
    for (int x = 300; x >= 238; x -= 2) begin
      p0x = 12'(x);
      tick(1);
    end
    check("clean_pass_score", score, 16'h0001);
    check("clean_pass_state", 16'(state), 16'd1);

    for (int i = 0; i < 98; i++) begin
      p0x = 12'd240; tick(1);
      p0x = 12'd238; tick(1);
    end
    check("score_99", score, 16'h0099);
    p0x = 12'd240; p1x = 12'd240; tick(1);
    p0x = 12'd238; p1x = 12'd238; tick(1);
    check("dual_pass_carry", score, 16'h0101);

    for (int i = 0; i < 4948; i++) begin
      p0x = 12'd240; p1x = 12'd240; tick(1);
      p0x = 12'd238; p1x = 12'd238; tick(1);
    end
    check("score_9997", score, 16'h9997);
    p0x = 12'd240; p1x = 12'd1000; tick(1);
    p0x = 12'd238; tick(1);
    check("score_9998", score, 16'h9998);
    p0x = 12'd240; p1x = 12'd240; tick(1);
    p0x = 12'd238; p1x = 12'd238; tick(1);
    check("saturate_dual", score, 16'h9999);
    p0x = 12'd240; tick(1);
    p0x = 12'd238; tick(1);
    check("saturate_single", score, 16'h9999);

    // pipe collision (top pipe), then HIT timing
    p0x = 12'd300; p1x = 12'd1000; bird_y = 10'd209; tick(1);
    check("collide_state", 16'(state), 16'd2);
    check("collide_freeze", 16'(freeze), 16'd1);
    check("collide_flash", 16'(hit_flash), 16'd1);
    check("collide_score_hold", score, 16'h9999);
    bird_y = 10'd250; p0x = 12'd1000;
    tick(59);
    check("hit_last_cycle", 16'(state), 16'd2);
    check("hit_last_flash", 16'(hit_flash), 16'd0);
    tick(1);
    check("over_state", 16'(state), 16'd3);
    check("over_flag", 16'(game_over), 16'd1);
    up = 1'b1; tick(1);
    check("over_to_idle", 16'(state), 16'd0);
    check("idle_score_hold", score, 16'h9999);
    up = 1'b0; tick(1);
    up = 1'b1; tick(1);
    check("restart_score", score, 16'h0000);
    up = 1'b0; tick(1);

    // floor and ceiling bounds
    bird_y = 10'd505; tick(1);
    check("floor_hit", 16'(state), 16'd2);
    bird_y = 10'd250; tick(60);
    go_play();
    bird_y = 10'd45; tick(1);
    check("ceiling_hit", 16'(state), 16'd2);
    bird_y = 10'd250; tick(60);
    go_play();
    bird_y = 10'd504; tick(1);
    check("floor_edge_safe", 16'(state), 16'd1);
    bird_y = 10'd46; tick(1);
    check("ceiling_edge_safe", 16'(state), 16'd1);
    bird_y = 10'd250;

    // async reset during HIT
    p0x = 12'd240; tick(1);
    p0x = 12'd238; tick(1);
    check("pre_reset_score", score, 16'h0001);
    p0x = 12'd1000; bird_y = 10'd505; tick(1);
    bird_y = 10'd250; tick(10);
    #1 rst = 1'b0;
    #1;
    check("async_state", 16'(state), 16'd0);
    check("async_score", score, 16'h0000);
    check("async_freeze", 16'(freeze), 16'd1);
    check("async_flash", 16'(hit_flash), 16'd0);
    tick(2);
    rst = 1'b1;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
